clause_loader: RTL and testbench
================================

CLAUSE_LOADER -- requirements
Module: clause_loader

Interface
REQ-001 Parameter NUM_CLAUSES, default 8; number of clause slots in the downstream clause array.
REQ-002 Parameter NUM_VARS, default 8; literals per clause, 2 bits each.
REQ-003 Parameter WIDTH_C_LEN, default 4; clause-length field width.
REQ-004 Port clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port start_load_i  input  1  one-cycle pulse; begins a load of num_clauses_i clauses.
REQ-007 Port start_store_i  input  1  one-cycle pulse; begins readback of all NUM_CLAUSES slots.
REQ-008 Port num_clauses_i  input  $clog2(NUM_CLAUSES+1)  clause count; sampled on start_load_i.
REQ-009 Port src_clause_i  input  NUM_VARS*2  incoming clause beat.
REQ-010 Port src_len_i  input  WIDTH_C_LEN  incoming clause length.
REQ-011 Port src_valid_i / src_ready_o  input / output  1 each  source handshake.
REQ-012 Port wr_o / rd_o  output  NUM_CLAUSES each  one-hot slot write/read strobes to the array.
REQ-013 Port clause_o / clause_len_o  output  NUM_VARS*2 / WIDTH_C_LEN  write data to the array.
REQ-014 Port clause_i  input  NUM_VARS*2  array read data, valid combinationally in the same cycle as rd_o.
REQ-015 Port store_clause_o / store_valid_o / store_ready_i  output / output / input  NUM_VARS*2 / 1 / 1  readback sink handshake.
REQ-016 Port busy_o / done_o  output  1 each  busy while not IDLE; done_o is a one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be: IDLE, LOAD, CLEAR, STORE_RD, STORE_WAIT, DONE.
REQ-018 IDLE: start_load_i -> LOAD, slot counter = 0, count = min(num_clauses_i, NUM_CLAUSES); start_store_i alone -> STORE_RD; both asserted together -> load wins.
REQ-019 Starts arriving outside IDLE SHALL be ignored.
REQ-020 LOAD: src_ready_o = 1; each beat with src_valid_i && src_ready_o SHALL give wr_o = one-hot(counter), clause_o = src_clause_i and clause_len_o = src_len_i, all registered, in the next cycle; the counter then increments.
REQ-021 When the counter reaches count, LOAD SHALL go to CLEAR if count < NUM_CLAUSES, otherwise to DONE; count = 0 SHALL go straight to CLEAR.
REQ-022 CLEAR: src_ready_o = 0; one remaining slot is written per cycle with clause_o = 0 and clause_len_o = 0, up to slot NUM_CLAUSES-1; then DONE.
REQ-023 STORE_RD: rd_o = one-hot(counter) for one cycle; clause_i SHALL be captured into store_clause_o and store_valid_o set; next state STORE_WAIT.
REQ-024 STORE_WAIT: store_valid_o and store_clause_o SHALL be held stable until store_ready_i; on handshake, counter increments -> STORE_RD, or -> DONE after slot NUM_CLAUSES-1.
REQ-025 DONE: done_o = 1 for exactly one cycle, then IDLE.
REQ-026 wr_o and rd_o SHALL never both be nonzero, and each SHALL have at most one bit set.
REQ-027 wr_o and rd_o SHALL be 0 in every cycle without an active slot access.

Reset
REQ-028 On rst: state IDLE, counters 0; wr_o, rd_o, clause_o, clause_len_o, store_clause_o, store_valid_o, src_ready_o, busy_o and done_o all 0.
REQ-029 rst mid-operation SHALL abort the operation with no further strobes and no done_o pulse.

Configuration
REQ-030 Macro CLAUSE_LOADER_READBACK_EN: defined -> STORE_RD/STORE_WAIT and the store port behaviour as above; undefined -> start_store_i ignored, rd_o, store_clause_o and store_valid_o tied 0, ports retained.

Structure
REQ-031 A shared package sat_pkg SHALL hold the state enum and the literal encoding constants (2-bit literal codes).
REQ-032 Sub-module onehot_dec (binary counter to NUM_CLAUSES one-hot) is natural for the wr_o/rd_o generation.

Verification
REQ-033 Load 3 clauses (0xA5A5/len 2, 0x1234/len 3, 0xFFFF/len 8), src_valid_i held high -> wr_o = 0x01, 0x02, 0x04 with matching data, then 0x08..0x80 with zero data, one done_o pulse.
REQ-034 Load 8 clauses with src_valid_i toggling every other cycle -> exactly 8 writes, wr_o 0x01..0x80 in order, no CLEAR cycles.
REQ-035 Load with num_clauses_i = 0 and then 12 -> first case clears all 8 slots; second is clamped to 8 writes.
REQ-036 Readback (macro defined) with store_ready_i low for 3 cycles per beat -> rd_o asserted one cycle per slot, store_clause_o stable while stalled, 8 handshakes, then done_o.
REQ-037 start_load_i and start_store_i asserted in the same cycle -> load executes; a start_store_i during LOAD is ignored.
REQ-038 rst asserted after the 2nd write of a 5-clause load -> all outputs 0 in the next cycle and no done_o pulse; a subsequent load behaves normally.

Source files
------------

// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared loader FSM states and 2-bit literal encodings
package sat_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CLEAR,
      STORE_RD,
      STORE_WAIT,
      DONE
   } loader_state_e;

   // A literal slot carries one of these codes per variable
   localparam logic [1:0] LIT_ABSENT = 2'b00;
   localparam logic [1:0] LIT_POS    = 2'b01;
   localparam logic [1:0] LIT_NEG    = 2'b10;
   localparam logic [1:0] LIT_BOTH   = 2'b11;

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - binary slot index to one-hot strobe vector
// Indices at or beyond N decode to all zeros.
module onehot_dec #(
   parameter int N = 8,
   parameter int W = $clog2(N + 1)
) (
   input  logic [W-1:0] idx_i,
   output logic [N-1:0] oh_o
);

   always_comb begin
      oh_o = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_i == W'(i)) oh_o[i] = 1'b1;
      end
   end

endmodule

// File: rtl/clause_loader.sv
// rtl/clause_loader.sv - loads clauses into a slot array, zero-fills the rest, optional readback
// Readback path enabled by defining CLAUSE_LOADER_READBACK_EN.
module clause_loader
   import sat_pkg::*;
#(
   parameter int NUM_CLAUSES = 8,
   parameter int NUM_VARS    = 8,
   parameter int WIDTH_C_LEN = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start_load_i,
   input  logic                               start_store_i,
   input  logic [$clog2(NUM_CLAUSES+1)-1:0]   num_clauses_i,
   input  logic [NUM_VARS*2-1:0]              src_clause_i,
   input  logic [WIDTH_C_LEN-1:0]             src_len_i,
   input  logic                               src_valid_i,
   output logic                               src_ready_o,
   output logic [NUM_CLAUSES-1:0]             wr_o,
   output logic [NUM_CLAUSES-1:0]             rd_o,
   output logic [NUM_VARS*2-1:0]              clause_o,
   output logic [WIDTH_C_LEN-1:0]             clause_len_o,
   input  logic [NUM_VARS*2-1:0]              clause_i,
   output logic [NUM_VARS*2-1:0]              store_clause_o,
   output logic                               store_valid_o,
   input  logic                               store_ready_i,
   output logic                               busy_o,
   output logic                               done_o
);

   localparam int CW = $clog2(NUM_CLAUSES + 1);
   localparam int DW = NUM_VARS * 2;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_CLAUSES);
   localparam logic [CW-1:0] CNT_LAST = CW'(NUM_CLAUSES - 1);

   loader_state_e          state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [CW-1:0]          count_q, count_d;
   logic [NUM_CLAUSES-1:0] wr_q, wr_d;
   logic [DW-1:0]          clause_q, clause_d;
   logic [WIDTH_C_LEN-1:0] len_q, len_d;
   logic [DW-1:0]          st_clause_q, st_clause_d;
   logic                   st_valid_q, st_valid_d;
   logic [NUM_CLAUSES-1:0] slot_oh;

   onehot_dec #(.N(NUM_CLAUSES), .W(CW)) u_slot_dec (
      .idx_i (cnt_q),
      .oh_o  (slot_oh)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      count_d     = count_q;
      wr_d        = '0;
      clause_d    = '0;
      len_d       = '0;
      st_clause_d = st_clause_q;
      st_valid_d  = st_valid_q;
      case (state_q)
         IDLE: begin
            if (start_load_i) begin
               cnt_d   = '0;
               count_d = (num_clauses_i > CNT_MAX) ? CNT_MAX : num_clauses_i;
               state_d = (num_clauses_i == '0) ? CLEAR : LOAD;
            end
`ifdef CLAUSE_LOADER_READBACK_EN
            else if (start_store_i) begin
               cnt_d   = '0;
               state_d = STORE_RD;
            end
`endif
         end
         LOAD: begin
            if (src_valid_i) begin
               wr_d     = slot_oh;
               clause_d = src_clause_i;
               len_d    = src_len_i;
               cnt_d    = cnt_q + CNT_ONE;
               if (cnt_q + CNT_ONE == count_q) begin
                  state_d = (count_q == CNT_MAX) ? DONE : CLEAR;
               end
            end
         end
         CLEAR: begin
            // Zero-fill so stale clauses from an earlier load cannot survive
            wr_d  = slot_oh;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
`ifdef CLAUSE_LOADER_READBACK_EN
         STORE_RD: begin
            st_clause_d = clause_i;
            st_valid_d  = 1'b1;
            state_d     = STORE_WAIT;
         end
         STORE_WAIT: begin
            if (store_ready_i) begin
               st_valid_d = 1'b0;
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
                  state_d = STORE_RD;
               end
            end
         end
`endif
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         count_q     <= '0;
         wr_q        <= '0;
         clause_q    <= '0;
         len_q       <= '0;
         st_clause_q <= '0;
         st_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         count_q     <= count_d;
         wr_q        <= wr_d;
         clause_q    <= clause_d;
         len_q       <= len_d;
         st_clause_q <= st_clause_d;
         st_valid_q  <= st_valid_d;
      end
   end

   assign src_ready_o  = (state_q == LOAD);
   assign wr_o         = wr_q;
   assign clause_o     = clause_q;
   assign clause_len_o = len_q;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);

`ifdef CLAUSE_LOADER_READBACK_EN
   // Array read data is combinational, so the read strobe is too
   assign rd_o           = (state_q == STORE_RD) ? slot_oh : '0;
   assign store_clause_o = st_clause_q;
   assign store_valid_o  = st_valid_q;
`else
   logic unused_readback;
   assign unused_readback = ^{clause_i, store_ready_i, start_store_i, st_clause_q, st_valid_q};
   assign rd_o           = '0;
   assign store_clause_o = '0;
   assign store_valid_o  = 1'b0;
`endif

endmodule

// File: tb/tb_clause_loader.sv
// tb/tb_clause_loader.sv - randomized self-checking bench for clause_loader against a slot-array model
module tb_clause_loader;

   localparam int NC = 8;
   localparam int NV = 8;
   localparam int WL = 4;
   localparam int CW = $clog2(NC + 1);
   localparam int DW = NV * 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_load_i, start_store_i;
   logic [CW-1:0] num_clauses_i;
   logic [DW-1:0] src_clause_i;
   logic [WL-1:0] src_len_i;
   logic          src_valid_i, src_ready_o;
   logic [NC-1:0] wr_o, rd_o;
   logic [DW-1:0] clause_o, clause_i, store_clause_o;
   logic [WL-1:0] clause_len_o;
   logic          store_valid_o, store_ready_i, busy_o, done_o;

   always #5 clk = ~clk;

   clause_loader #(.NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_C_LEN(WL)) dut (
      .clk(clk), .rst(rst),
      .start_load_i(start_load_i), .start_store_i(start_store_i),
      .num_clauses_i(num_clauses_i),
      .src_clause_i(src_clause_i), .src_len_i(src_len_i),
      .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
      .wr_o(wr_o), .rd_o(rd_o),
      .clause_o(clause_o), .clause_len_o(clause_len_o),
      .clause_i(clause_i),
      .store_clause_o(store_clause_o), .store_valid_o(store_valid_o),
      .store_ready_i(store_ready_i),
      .busy_o(busy_o), .done_o(done_o)
   );

   typedef struct {
      int            slot;
      logic [DW-1:0] c;
      logic [WL-1:0] l;
   } wr_t;

   wr_t           exp_q[$];
   logic [DW-1:0] arr[NC];
   logic [WL-1:0] arr_len[NC];
   logic [DW-1:0] mdl_mem[NC];
   logic [DW-1:0] stim_dat[NC];
   logic [WL-1:0] stim_len[NC];
   int checks = 0, errors = 0;
   int done_cnt = 0, wr_seen = 0, rd_seen = 0, rd_idx = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // The emulated array returns stored data combinationally on the read strobe
   always_comb begin
      clause_i = '0;
      for (int i = 0; i < NC; i++) if (rd_o[i]) clause_i = arr[i];
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("wr_rd_exclusive", {63'd0, (wr_o != '0) && (rd_o != '0)}, 64'd0);
         chk("wr_onehot", {63'd0, $countones(wr_o) <= 1}, 64'd1);
         chk("rd_onehot", {63'd0, $countones(rd_o) <= 1}, 64'd1);
         if (wr_o != '0) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual=%h required=none", wr_o);
            end else begin
               wr_t e;
               logic [NC-1:0] m;
               e = exp_q.pop_front();
               m = '0;
               m[e.slot] = 1'b1;
               chk("wr_slot", wr_o, m);
               chk("wr_clause", clause_o, e.c);
               chk("wr_len", clause_len_o, e.l);
            end
            for (int i = 0; i < NC; i++) begin
               if (wr_o[i]) begin
                  arr[i]     = clause_o;
                  arr_len[i] = clause_len_o;
               end
            end
         end
         if (rd_o != '0) begin
            logic [NC-1:0] m;
            m = '0;
            if (rd_idx < NC) m[rd_idx] = 1'b1;
            chk("rd_slot", rd_o, m);
            rd_seen++;
            rd_idx++;
         end
         if (done_o) done_cnt++;
      end
   end

   task automatic chk_all_zero(input string name);
      chk(name, {wr_o, rd_o, clause_o, clause_len_o, store_clause_o,
                 store_valid_o, src_ready_o, busy_o, done_o}, 64'd0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < NC; i++) begin
         stim_dat[i] = DW'($urandom) | DW'(1);
         stim_len[i] = WL'($urandom);
      end
   endtask

   task automatic wait_done(input int d0);
      int t = 0;
      while (done_cnt == d0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulses", done_cnt - d0, 1);
      chk("writes_drained", exp_q.size(), 0);
      chk("idle_after_done", {63'd0, busy_o}, 64'd0);
   endtask

   // mode 0: valid held high, 1: toggling, 2: random
   task automatic do_load(input int n, input int mode, input bit also_store, input bit store_mid);
      int k, b, cyc, d0;
      bit hs;
      k = (n > NC) ? NC : n;
      for (int i = 0; i < NC; i++) begin
         wr_t e;
         e.slot = i;
         e.c = (i < k) ? stim_dat[i] : '0;
         e.l = (i < k) ? stim_len[i] : '0;
         mdl_mem[i] = e.c;
         exp_q.push_back(e);
      end
      d0 = done_cnt;
      @(posedge clk); #1;
      start_load_i  = 1'b1;
      start_store_i = also_store;
      num_clauses_i = CW'(n);
      @(posedge clk); #1;
      start_load_i  = 1'b0;
      start_store_i = 1'b0;
      b = 0;
      cyc = 0;
      while (b < k && cyc < 400) begin
         src_valid_i   = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom);
         src_clause_i  = stim_dat[b];
         src_len_i     = stim_len[b];
         start_store_i = store_mid && (cyc == 1);
         @(negedge clk);
         hs = src_valid_i && src_ready_o;
         @(posedge clk); #1;
         start_store_i = 1'b0;
         if (hs) b++;
         cyc++;
      end
      src_valid_i = 1'b0;
      chk("load_beats_accepted", b, k);
      wait_done(d0);
   endtask

`ifdef CLAUSE_LOADER_READBACK_EN
   task automatic do_store();
      int d0, r0, t;
      logic [DW-1:0] v;
      d0 = done_cnt;
      r0 = rd_seen;
      rd_idx = 0;
      @(posedge clk); #1;
      start_store_i = 1'b1;
      @(posedge clk); #1;
      start_store_i = 1'b0;
      for (int k = 0; k < NC; k++) begin
         t = 0;
         @(negedge clk);
         while (!store_valid_o && t < 30) begin
            @(negedge clk);
            t++;
         end
         chk("store_valid_seen", {63'd0, store_valid_o}, 64'd1);
         if (!store_valid_o) break;
         v = store_clause_o;
         chk("store_data", v, mdl_mem[k]);
         repeat (2) begin
            @(negedge clk);
            chk("store_stable", {store_valid_o, store_clause_o}, {1'b1, v});
         end
         store_ready_i = 1'b1;
         @(posedge clk); #1;
         store_ready_i = 1'b0;
      end
      wait_done(d0);
      chk("store_reads", rd_seen - r0, NC);
   endtask
`endif

   initial begin
      int d0, w0, r0, b;
      bit hs;
      rst = 1'b1;
      start_load_i = 1'b0; start_store_i = 1'b0; num_clauses_i = '0;
      src_clause_i = '0; src_len_i = '0; src_valid_i = 1'b0; store_ready_i = 1'b0;
      for (int i = 0; i < NC; i++) begin
         arr[i] = '1;
         arr_len[i] = '1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset_state");
      @(posedge clk); #1;
      rst = 1'b0;

      // Full load with valid toggling: exactly eight writes, no zero-fill
      fill_random();
      w0 = wr_seen;
      do_load(8, 1, 1'b0, 1'b0);
      chk("toggle_write_count", wr_seen - w0, 8);

      // Three fixed clauses then zero-fill of slots 3..7
      stim_dat[0] = 16'hA5A5; stim_len[0] = 4'd2;
      stim_dat[1] = 16'h1234; stim_len[1] = 4'd3;
      stim_dat[2] = 16'hFFFF; stim_len[2] = 4'd8;
      w0 = wr_seen;
      do_load(3, 0, 1'b0, 1'b0);
      chk("fixed_write_count", wr_seen - w0, 8);
      chk("slot0_data", arr[0], 16'hA5A5);
      chk("slot0_len", arr_len[0], 4'd2);
      chk("slot1_data", arr[1], 16'h1234);
      chk("slot2_data", arr[2], 16'hFFFF);
      chk("slot2_len", arr_len[2], 4'd8);
      chk("slot3_cleared", {arr[3], arr_len[3]}, 0);
      chk("slot7_cleared", {arr[7], arr_len[7]}, 0);

      // Zero count clears everything; oversize count clamps
      w0 = wr_seen;
      do_load(0, 0, 1'b0, 1'b0);
      chk("zero_count_writes", wr_seen - w0, 8);
      chk("zero_count_slot0", arr[0], 0);
      fill_random();
      w0 = wr_seen;
      do_load(12, 2, 1'b0, 1'b0);
      chk("clamped_writes", wr_seen - w0, 8);
      chk("clamped_slot7", arr[7], stim_dat[7]);

      // Simultaneous starts and a store start during load are both load-only
      fill_random();
      r0 = rd_seen;
      do_load(4, 0, 1'b1, 1'b0);
      fill_random();
      do_load(6, 2, 1'b0, 1'b1);
      chk("no_reads_from_ignored_store", rd_seen - r0, 0);

      // Reset after the second write of a five-clause load
      fill_random();
      for (int i = 0; i < NC; i++) begin
         wr_t e;
         e.slot = i;
         e.c = (i < 5) ? stim_dat[i] : '0;
         e.l = (i < 5) ? stim_len[i] : '0;
         exp_q.push_back(e);
      end
      d0 = done_cnt;
      w0 = wr_seen;
      @(posedge clk); #1;
      start_load_i = 1'b1;
      num_clauses_i = CW'(5);
      @(posedge clk); #1;
      start_load_i = 1'b0;
      b = 0;
      for (int c = 0; c < 40; c++) begin
         src_valid_i  = 1'b1;
         src_clause_i = stim_dat[b];
         src_len_i    = stim_len[b];
         @(negedge clk); #1;
         hs = src_valid_i && src_ready_o;
         if (wr_seen >= w0 + 2) break;
         @(posedge clk); #1;
         if (hs && b < NC - 1) b++;
      end
      chk("abort_reached_second_write", wr_seen - w0, 2);
      rst = 1'b1;
      src_valid_i = 1'b0;
      @(negedge clk);
      chk_all_zero("abort_outputs_zero");
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_no_more_writes", wr_seen - w0, 2);
      fill_random();
      w0 = wr_seen;
      do_load(5, 0, 1'b0, 1'b0);
      chk("post_abort_writes", wr_seen - w0, 8);

`ifdef CLAUSE_LOADER_READBACK_EN
      do_store();
`else
      d0 = done_cnt;
      @(posedge clk); #1;
      start_store_i = 1'b1;
      @(posedge clk); #1;
      start_store_i = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("store_ignored", {busy_o, store_valid_o, rd_o}, 0);
      end
      chk("store_ignored_no_done", done_cnt - d0, 0);
`endif

      for (int it = 0; it < 6; it++) begin
         fill_random();
         do_load(int'($urandom_range(0, 12)), 2, 1'b0, 1'b0);
`ifdef CLAUSE_LOADER_READBACK_EN
         do_store();
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
